acc_seq_ctrl: RTL and testbench

//  Sequencer for the counter -> FIFO -> acc_core datapath. On start, enables the counter to

---
 rtl/acc_seq_pkg.sv | 15 +
 rtl/acc_seq_ctrl.sv | 157 +++++++++++++++
 tb/tb_acc_seq_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/acc_seq_pkg.sv
// rtl/acc_seq_pkg.sv - state encodings and length-width helper for acc_seq_ctrl
package acc_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  function automatic int len_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/acc_seq_ctrl.sv
// rtl/acc_seq_ctrl.sv - sequencer driving counter -> FIFO -> acc_core through fill, drain and flush
module acc_seq_ctrl
  import acc_seq_pkg::*;
#(
  parameter int DWIDTH     = 4,
  parameter int RWIDTH     = 2 * DWIDTH,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64,
  localparam int LEN_W     = len_width(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              abort_i,
  input  logic              fifo_full_i,
  input  logic              fifo_empty_i,
  input  logic              acc_valid_i,
  input  logic [RWIDTH-1:0] acc_result_i,
  output logic              cnt_en_o,
  output logic              fifo_rden_o,
  output logic              acc_valid_o,
  output logic              acc_run_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [RWIDTH-1:0] result_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  state_t            state, state_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic [LEN_W-1:0]  wr_cnt, wr_n;
  logic [LEN_W-1:0]  rd_cnt, rd_n;
  logic [TMO_W-1:0]  tmo, tmo_n;
  logic              en_n, rden_n, av_n, run_n, done_n, err_n, capture;
  logic              len_ok;

  assign len_ok = (len_i != '0) && (len_i <= LEN_W'(FIFO_DEPTH));

  always_comb begin
    state_n = state;
    len_n   = len_q;
    wr_n    = wr_cnt;
    rd_n    = rd_cnt;
    tmo_n   = tmo;
    en_n    = 1'b0;
    rden_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
    capture = 1'b0;

    case (state)
      // done_o still high means the job just finished; a start here is dropped, not queued
      S_IDLE: begin
        if (start_i && !done_o) begin
          if (len_ok) begin
            len_n   = len_i;
            wr_n    = '0;
            rd_n    = '0;
            tmo_n   = '0;
            state_n = S_FILL;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      // a full FIFO before len words means stale entries; shrink the job to what was written
      S_FILL: begin
        if (wr_cnt == len_q) begin
          state_n = S_DRAIN;
        end else if (fifo_full_i) begin
          len_n   = wr_cnt;
          state_n = S_DRAIN;
        end else begin
          en_n = 1'b1;
          wr_n = wr_cnt + LEN_W'(1);
        end
      end
      // leave only after the last read's acc_valid_o is on the bus
      S_DRAIN: begin
        if (rd_cnt != wr_cnt) begin
          if (!fifo_empty_i) begin
            rden_n = 1'b1;
            rd_n   = rd_cnt + LEN_W'(1);
          end
        end else if (!fifo_rden_o) begin
          state_n = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (acc_valid_i) begin
          capture = 1'b1;
          done_n  = 1'b1;
          state_n = S_IDLE;
        end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
          err_n   = 1'b1;
          state_n = S_IDLE;
        end else begin
          tmo_n = tmo + TMO_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (abort_i) begin
      state_n = S_IDLE;
      wr_n    = '0;
      rd_n    = '0;
      tmo_n   = '0;
      en_n    = 1'b0;
      rden_n  = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b0;
      capture = 1'b0;
    end
  end

  assign av_n  = fifo_rden_o && !abort_i;
  assign run_n = (state_n == S_FLUSH) && (state != S_FLUSH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      len_q       <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      tmo         <= '0;
      cnt_en_o    <= 1'b0;
      fifo_rden_o <= 1'b0;
      acc_valid_o <= 1'b0;
      acc_run_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      result_o    <= '0;
    end else begin
      state       <= state_n;
      len_q       <= len_n;
      wr_cnt      <= wr_n;
      rd_cnt      <= rd_n;
      tmo         <= tmo_n;
      cnt_en_o    <= en_n;
      fifo_rden_o <= rden_n;
      acc_valid_o <= av_n;
      acc_run_o   <= run_n;
      busy_o      <= (state_n != S_IDLE);
      done_o      <= done_n;
      err_o       <= err_n;
      if (capture) begin
        result_o <= acc_result_i;
      end
    end
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// tb/tb_acc_seq_ctrl.sv - table-driven bench for acc_seq_ctrl with counter/FIFO/acc_core models
module tb_acc_seq_ctrl;

  localparam int DEPTH = 8;
  localparam int LEN_W = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start_i;
  logic [LEN_W-1:0] len_i;
  logic       abort_i;
  logic       fifo_full_i;
  logic       fifo_empty_i;
  logic       acc_valid_i;
  logic [7:0] acc_result_i;
  logic       cnt_en_o, fifo_rden_o, acc_valid_o, acc_run_o, busy_o, done_o, err_o;
  logic [7:0] result_o;

  always #5 clk = ~clk;

  acc_seq_ctrl dut (
    .clk(clk), .reset(reset), .start_i(start_i), .len_i(len_i), .abort_i(abort_i),
    .fifo_full_i(fifo_full_i), .fifo_empty_i(fifo_empty_i),
    .acc_valid_i(acc_valid_i), .acc_result_i(acc_result_i),
    .cnt_en_o(cnt_en_o), .fifo_rden_o(fifo_rden_o), .acc_valid_o(acc_valid_o),
    .acc_run_o(acc_run_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .result_o(result_o)
  );

  // Datapath models: counter words start at 1, FIFO flags include the write/read on the bus this cycle
  logic       tb_flush, tb_push, respond, force_empty, fe_d;
  logic [3:0] mem [0:15];
  logic [3:0] cval, rdata;
  logic [7:0] acc_sum;
  int wp, rp, cyc, run_cyc, err_cyc;
  int n_en, n_rd, n_av, n_run, n_done, n_err, n_busy, n_rd_stalled;

  assign fifo_full_i  = (wp - rp + int'(cnt_en_o)) >= DEPTH;
  assign fifo_empty_i = ((wp - rp - int'(fifo_rden_o)) <= 0) || force_empty;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tb_flush) begin
      rp <= wp; cval <= 4'd1; acc_sum <= '0; acc_valid_i <= 1'b0; acc_result_i <= '0; fe_d <= 1'b0;
      n_en <= 0; n_rd <= 0; n_av <= 0; n_run <= 0; n_done <= 0; n_err <= 0; n_busy <= 0; n_rd_stalled <= 0;
    end else begin
      if (cnt_en_o || tb_push) begin
        mem[wp & 15] <= cval; wp <= wp + 1; cval <= cval + 4'd1;
      end
      if (fifo_rden_o) begin
        rdata <= mem[rp & 15]; rp <= rp + 1;
      end
      if (acc_valid_o) acc_sum <= acc_sum + {4'd0, rdata};
      acc_valid_i  <= acc_run_o && respond;
      acc_result_i <= acc_sum;
      fe_d <= force_empty;
      if (cnt_en_o)    n_en   <= n_en + 1;
      if (fifo_rden_o) n_rd   <= n_rd + 1;
      if (acc_valid_o) n_av   <= n_av + 1;
      if (acc_run_o)   begin n_run <= n_run + 1; run_cyc <= cyc; end
      if (done_o)      n_done <= n_done + 1;
      if (err_o)       begin n_err <= n_err + 1; err_cyc <= cyc; end
      if (busy_o)      n_busy <= n_busy + 1;
      if (fifo_rden_o && fe_d) n_rd_stalled <= n_rd_stalled + 1;
    end
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic flush();
    @(negedge clk); tb_flush = 1'b1;
    @(negedge clk); tb_flush = 1'b0;
  endtask

  task automatic start_job(input int len, input int pre, input bit resp);
    flush();
    respond = resp;
    for (int i = 0; i < pre; i++) begin
      tb_push = 1'b1; @(negedge clk);
    end
    tb_push = 1'b0;
    start_i = 1'b1; len_i = LEN_W'(len);
    @(negedge clk);
    start_i = 1'b0;
  endtask

  typedef struct {
    int len; int pre; bit stall; bit resp;
    int en; int rd; int av; int run; int done; int err; int res; bit idle;
  } vec_t;

  vec_t vecs[6];

  initial begin
    bit fin, stalled;
    int sc;

    reset = 1'b1; start_i = 1'b0; len_i = '0; abort_i = 1'b0;
    tb_flush = 1'b1; tb_push = 1'b0; respond = 1'b1; force_empty = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0; tb_flush = 1'b0;

    chk("rst_cnt_en", int'(cnt_en_o), 0);
    chk("rst_rden", int'(fifo_rden_o), 0);
    chk("rst_acc_valid", int'(acc_valid_o), 0);
    chk("rst_run", int'(acc_run_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_err", int'(err_o), 0);
    chk("rst_result", int'(result_o), 0);

    //          len pre st rs  en rd av run dn er res idle
    vecs[0] = '{4, 0, 0, 1,  4, 4, 4, 1, 1, 0, 10, 0};
    vecs[1] = '{0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 10, 1};
    vecs[2] = '{9, 0, 0, 1,  0, 0, 0, 0, 0, 1, 10, 1};
    vecs[3] = '{8, 2, 0, 1,  6, 6, 6, 1, 1, 0, 21, 0};
    vecs[4] = '{5, 0, 1, 1,  5, 5, 5, 1, 1, 0, 15, 0};
    vecs[5] = '{3, 0, 0, 0,  3, 3, 3, 1, 0, 1, 15, 0};

    for (int v = 0; v < 6; v++) begin
      start_job(vecs[v].len, vecs[v].pre, vecs[v].resp);
      fin = 1'b0; stalled = 1'b0; sc = 0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (vecs[v].stall && !stalled && n_rd >= 2) begin
          force_empty = 1'b1; sc = 3; stalled = 1'b1;
        end else if (sc > 0) begin
          sc--;
          if (sc == 0) force_empty = 1'b0;
        end
        if (n_done + n_err > 0) begin
          fin = 1'b1;
          break;
        end
      end
      force_empty = 1'b0;
      chk($sformatf("v%0d_finished", v), int'(fin), 1);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_cnt_en", v), n_en, vecs[v].en);
      chk($sformatf("v%0d_rden", v), n_rd, vecs[v].rd);
      chk($sformatf("v%0d_acc_valid", v), n_av, vecs[v].av);
      chk($sformatf("v%0d_run", v), n_run, vecs[v].run);
      chk($sformatf("v%0d_done", v), n_done, vecs[v].done);
      chk($sformatf("v%0d_err", v), n_err, vecs[v].err);
      chk($sformatf("v%0d_result", v), int'(result_o), vecs[v].res);
      chk($sformatf("v%0d_rden_in_stall", v), n_rd_stalled, 0);
      chk($sformatf("v%0d_busy_after", v), int'(busy_o), 0);
      if (vecs[v].idle) chk($sformatf("v%0d_busy_cycles", v), n_busy, 0);
    end
    chk("timeout_run_to_err", err_cyc - run_cyc, 64);

    // start presented during the done_o cycle must be dropped
    start_job(2, 0, 1'b1);
    fin = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done_o) begin fin = 1'b1; break; end
    end
    chk("done_seen", int'(fin), 1);
    start_i = 1'b1; len_i = 4'd2;
    @(negedge clk);
    start_i = 1'b0;
    chk("start_at_done_busy", int'(busy_o), 0);
    repeat (3) @(negedge clk);
    chk("start_at_done_writes", n_en, 2);
    chk("start_at_done_result", int'(result_o), 3);

    // abort in FILL after two writes
    start_job(6, 0, 1'b1);
    for (int i = 0; i < 50 && n_en < 2; i++) @(negedge clk);
    chk("abort_reached_2", int'(n_en >= 2), 1);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_busy", int'(busy_o), 0);
    chk("abort_cnt_en", int'(cnt_en_o), 0);
    repeat (10) @(negedge clk);
    chk("abort_done", n_done, 0);
    chk("abort_reads", n_rd, 0);
    chk("abort_result", int'(result_o), 3);

    // reset while draining
    start_job(3, 0, 1'b1);
    for (int i = 0; i < 50 && n_rd < 1; i++) @(negedge clk);
    chk("reset_reached_drain", int'(n_rd >= 1), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", int'(busy_o), 0);
    chk("reset_rden", int'(fifo_rden_o), 0);
    chk("reset_result", int'(result_o), 0);
    repeat (10) @(negedge clk);
    chk("reset_done", n_done, 0);
    chk("reset_run", n_run, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
